// File: rtl/finv_arbiter.sv
// Round-robin front end for a shared, non-pipelined reciprocal (finv) unit.
// Holds the operand steady for the lookup window and bypasses IEEE special cases.
//
// state | meaning
// IDLE  | no operation; winner of the round-robin search sees req_ready
// WAIT  | operand on finv_x, counting down the table-read window
// DONE  | resp_valid pulse to the owning requester
module finv_arbiter #(
    parameter int N_REQ = 2,
    parameter int LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_x,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [31:0]          resp_y,
    output logic                 busy,
    output logic [31:0]          finv_x,
    input  logic [31:0]          finv_y
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id;
    logic [CW-1:0]    cnt;
    logic [31:0]      op_reg;
    logic             special;

    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             accept;
    logic [31:0]      sel_x;
    logic [7:0]       sel_e;
    logic             sel_special;
    logic [31:0]      bypass_y;
    logic [N_REQ-1:0] id_onehot;

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept      = |(req_valid & req_ready);
    assign sel_x       = req_x[32*grant_idx +: 32];
    assign sel_e       = sel_x[30:23];
    // Exponent 253..255 gives a reciprocal below the normal range (or inf/NaN).
    assign sel_special = (sel_e == 8'd0) || (sel_e >= 8'd253);

    always_comb begin
        bypass_y = {op_reg[31], 31'b0};
        if (op_reg[30:23] == 8'd0) begin
            bypass_y = {op_reg[31], 8'hff, 23'b0};
        end else if (op_reg[30:23] == 8'hff && op_reg[22:0] != 23'd0) begin
            bypass_y = {op_reg[31], 8'hff, 1'b1, op_reg[21:0]};
        end
    end

    always_comb begin
        id_onehot     = '0;
        id_onehot[id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = WAIT;
            WAIT: if (cnt == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr     <= IDW'(N_REQ - 1);
            id         <= '0;
            op_reg     <= '0;
            special    <= 1'b0;
            cnt        <= '0;
            resp_valid <= '0;
            resp_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr  <= grant_idx;
                        id      <= grant_idx;
                        op_reg  <= sel_x;
                        special <= sel_special;
                        cnt     <= CW'(LAT);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_y     <= special ? bypass_y : finv_y;
                        resp_valid <= id_onehot;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: resp_valid <= '0;
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign finv_x = op_reg;

endmodule

// File: doc/finv_arbiter.md
Name: finv_arbiter

Overview:
- Shares one non-pipelined reciprocal unit (finv datapath, table lookup plus multiply-subtract) between N_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Holds the operand stable at the unit for the whole lookup window.
- Bypasses IEEE special cases (zero/denormal, inf, NaN, underflow) that the unit does not handle.
- Sits between the FPU issue logic (for example fdiv's reciprocal step, the finv instruction) and the finv instance.

Parameters:
N_REQ, 2, number of requesters (2..8).
LAT, 1, clock edges from a stable finv_x to a valid finv_y (table read latency).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rstn  input  1  asynchronous active-low reset.
req_valid  input  N_REQ  per-requester request strobe; held until accepted.
req_x  input  32*N_REQ  per-requester operand; slice i is bits [32i+31:32i].
req_ready  output  N_REQ  one-hot acceptance; combinational in IDLE.
resp_valid  output  N_REQ  one-hot, one-cycle result pulse to the owning requester.
resp_y  output  32  result; valid only while resp_valid is nonzero.
busy  output  1  high whenever state != IDLE.
finv_x  output  32  operand to the finv unit (registered).
finv_y  input  32  result from the finv unit.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE, rr_ptr = N_REQ-1, op_reg = 0, cnt = 0.
  - resp_valid = 0, resp_y = 0, finv_x = 0, busy = 0.
  - Any in-flight operation is dropped and produces no response. Requesters must re-issue.
- Round-robin grant:
  - Search starts at rr_ptr+1 mod N_REQ; the first asserted req_valid wins.
  - rr_ptr is loaded with the winner index only on acceptance.
  - After reset, requester 0 has highest priority.
- req_ready:
  - High only in IDLE, only for the winner, same cycle as its req_valid.
  - Accept = req_valid[i] & req_ready[i].
  - req_ready is 0 in every other state.
- FSM states: IDLE, WAIT, DONE.
- IDLE, on accept in cycle T (edge ending T):
  - op_reg <= req_x[i], id <= i.
  - Latch class flags from the operand.
  - cnt <= LAT, go to WAIT.
- WAIT:
  - finv_x = op_reg, held constant.
  - cnt decrements each edge.
  - On the edge where cnt == 0: resp_y <= (special ? bypass value : finv_y), resp_valid <= one-hot(id), go to DONE.
  - WAIT therefore lasts LAT+1 cycles.
- DONE (one cycle):
  - resp_valid is high this cycle.
  - Next edge clears resp_valid and returns to IDLE.
  - req_ready is 0 in DONE.
- Timing:
  - Latency is accept at T to resp_valid at T+LAT+2 (T+3 for LAT=1).
  - Back-to-back throughput is one op per LAT+3 cycles.
- No response backpressure: the requester must sample resp_y in the resp_valid cycle.
- Special cases (s = x[31], e = x[30:23], m = x[22:0]), evaluated in priority order:
  1. e == 0 (zero or denormal): resp_y = {s, 8'hff, 23'b0} (±inf).
  2. e == 255, m != 0 (NaN): resp_y = {s, 8'hff, 1'b1, m[21:0]} (quiet NaN).
  3. e == 255, m == 0 (inf): resp_y = {s, 31'b0} (±0).
  4. e >= 253 (result below normal range): resp_y = {s, 31'b0} (flush to ±0).
  5. Otherwise: resp_y = finv_y unchanged.
- For bypassed ops the FSM still runs the full WAIT window, so latency is uniform.
- req_x is sampled only at acceptance. Changes to req_x or req_valid while busy have no effect.
- Simultaneous requests: exactly one is granted per acceptance; the others wait in IDLE of a later operation.

Test Plan:
1. Reset release with req_valid[0] = 1, req_x0 = 32'h40000000 (2.0), model finv returns 32'h3f000000 -> req_ready[0] high in cycle T; resp_valid = 2'b01 at T+3; resp_y = 32'h3f000000; busy high T+1..T+3.
2. Both requesters held valid continuously (x0 = 32'h40800000, x1 = 32'h3f800000) -> grants alternate 0,1,0,1; responses spaced 4 cycles apart; each resp_valid one-hot matches its grant order.
3. Special operands: 32'h00000000 -> 32'h7f800000; 32'h80000000 -> 32'hff800000; 32'h7f800000 -> 32'h00000000; 32'h7f800001 -> 32'h7fc00001; 32'h7e800000 -> 32'h00000000. The bench drives finv_y = 32'hdeadbeef to prove the bypass, and each result arrives at T+3.
4. Operand hold: accept x = 32'h40400000, then change req_x0 every cycle during WAIT -> finv_x stays 32'h40400000 for all LAT+1 WAIT cycles; resp_y equals the model value for 3.0.
5. Reset mid-operation: rstn low during WAIT -> outputs zero immediately, no resp_valid after release; the next request from requester 0 is granted first and completes normally.
6. LAT = 3 build -> accept to resp_valid is 5 cycles; finv_x is stable for 4 cycles.
